// File: rtl/sisr_bist_pkg.sv
// Shared types and helpers for the SISR BIST controller slice.
// Holds the controller state encoding, the signature width, the PRPG seed
// and the serial-input signature register next-state function.
package sisr_bist_pkg;

   localparam int SIG_W = 4;

   localparam logic [SIG_W-1:0] PRPG_SEED = 4'b0001;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2,
      CHECK = 2'd3
   } state_t;

   // One compaction step: the serial bit enters at q0, the feedback tap q3
   // also folds into q1, and the remaining stages simply shift up.
   function automatic logic [SIG_W-1:0] sisr_next(input logic [SIG_W-1:0] q,
                                                  input logic             i);
      logic [SIG_W-1:0] r;
      r[0] = i ^ q[3];
      r[1] = q[3] ^ q[0];
      r[2] = q[1];
      r[3] = q[2];
      return r;
   endfunction

endpackage

// File: rtl/sisr_core.sv
// 4-bit serial-input signature register.
// Cleared and advanced only through synchronous controls so that the
// controller never has to touch the asynchronous reset to start a session.
module sisr_core
   import sisr_bist_pkg::*;
(
   input  logic             clk,
   input  logic             rst_b,
   input  logic             clr,
   input  logic             en,
   input  logic             i,
   output logic [SIG_W-1:0] q
);

   // Signature register: clear wins over enable, otherwise compact one bit.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en) begin
         q <= sisr_next(q, i);
      end
   end

endmodule

// File: rtl/sisr_bist_ctrl.sv
// SISR BIST session controller: clears the signature register, compacts a
// programmed number of serial bits, then compares against a golden value and
// reports pass/fail with a one-cycle done pulse.
// Optional build macro SISR_BIST_PRPG_EN replaces the external bit stream with
// an internal 4-bit pattern generator that feeds one bit every RUN cycle.
module sisr_bist_ctrl
   import sisr_bist_pkg::*;
#(
   parameter int CNT_W = 8
)
(
   input  logic             clk,
   input  logic             rst_b,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] len,
   input  logic [SIG_W-1:0] golden,
   input  logic             bit_i,
   input  logic             bit_vld,
   output logic             bit_rdy,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [SIG_W-1:0] sig
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SIG_W-1:0] gold_q, gold_d;
   logic             pass_q, pass_d;
   logic             done_q, done_d;
   logic             sigClr;
   logic             sigEn;
   logic             feedBit;
   logic             rdyRun;

`ifdef SISR_BIST_PRPG_EN
   logic [SIG_W-1:0] prpg_q, prpg_d;
   logic [SIG_W-1:0] prpgAdv;

   // The generator advances first and the freshly shifted-in MSB is the bit
   // compacted in that cycle, so a seed of 0001 yields the stream 0,0,1,0.
   assign prpgAdv = {prpg_q[2:0], prpg_q[3] ^ prpg_q[2]};
   assign feedBit = prpgAdv[3];
   assign bit_rdy = 1'b0;

   // Pattern generator: reseeded in CLEAR, stepped on every compacted bit.
   always_comb begin
      prpg_d = prpg_q;
      if (state_q == CLEAR && !abort) begin
         prpg_d = PRPG_SEED;
      end else if (sigEn) begin
         prpg_d = prpgAdv;
      end
   end

   // Pattern generator register.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         prpg_q <= '0;
      end else begin
         prpg_q <= prpg_d;
      end
   end
`else
   assign feedBit = bit_i;
   assign bit_rdy = rdyRun;
`endif

   // Next-state and datapath control; abort always wins over any progress so
   // that signature and pass freeze exactly where the session stopped.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gold_d  = gold_q;
      pass_d  = pass_q;
      done_d  = 1'b0;
      sigClr  = 1'b0;
      sigEn   = 1'b0;
      rdyRun  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = CLEAR;
               cnt_d   = len;
               gold_d  = golden;
            end
         end
         CLEAR: begin
            if (abort) begin
               state_d = IDLE;
            end else begin
               sigClr  = 1'b1;
               pass_d  = 1'b0;
               state_d = (cnt_q == '0) ? CHECK : RUN;
            end
         end
         RUN: begin
            rdyRun = 1'b1;
            if (abort) begin
               state_d = IDLE;
`ifdef SISR_BIST_PRPG_EN
            end else begin
`else
            end else if (bit_vld) begin
`endif
               sigEn = 1'b1;
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = CHECK;
               end
            end
         end
         CHECK: begin
            state_d = IDLE;
            if (!abort) begin
               pass_d = (sig == gold_q);
               done_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Controller registers: state, remaining-bit counter, golden copy, result.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         gold_q  <= '0;
         pass_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gold_q  <= gold_d;
         pass_q  <= pass_d;
         done_q  <= done_d;
      end
   end

   sisr_core uSisr (
      .clk   (clk),
      .rst_b (rst_b),
      .clr   (sigClr),
      .en    (sigEn),
      .i     (feedBit),
      .q     (sig)
   );

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign pass = pass_q;

endmodule

// File: tb/tb_sisr_bist_ctrl.sv
// Self-checking bench for sisr_bist_ctrl (default build, external bit stream).
// Expected signatures and pass flags come from a small reference model and
// are queued when a session is launched, then compared when done pulses.
module tb_sisr_bist_ctrl;

   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_b;
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] len;
   logic [3:0]       golden;
   logic             bit_i;
   logic             bit_vld;
   logic             bit_rdy;
   logic             busy;
   logic             done;
   logic             pass;
   logic [3:0]       sig;

   int errorCount = 0;
   int checkCount = 0;

   typedef struct packed {
      logic [3:0] sig;
      logic       pass;
   } expect_t;

   expect_t scoreQ[$];

   always #5 clk = ~clk;

   sisr_bist_ctrl #(.CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rst_b   (rst_b),
      .start   (start),
      .abort   (abort),
      .len     (len),
      .golden  (golden),
      .bit_i   (bit_i),
      .bit_vld (bit_vld),
      .bit_rdy (bit_rdy),
      .busy    (busy),
      .done    (done),
      .pass    (pass),
      .sig     (sig)
   );

   // Reference model of one compaction step.
   function automatic logic [3:0] modelStep(input logic [3:0] q, input logic b);
      logic [3:0] r;
      r[0] = b ^ q[3];
      r[1] = q[3] ^ q[0];
      r[2] = q[1];
      r[3] = q[2];
      return r;
   endfunction

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Advance one clock and settle just after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Bounded wait for the done pulse, checking how many edges it took.
   task automatic waitDone(input int expEdges, input string tag);
      int  edges;
      bit  seen;
      edges = 0;
      seen  = 1'b0;
      for (int k = 1; k <= 20 && !seen; k++) begin
         step();
         if (done === 1'b1) begin
            seen  = 1'b1;
            edges = k;
         end
      end
      checkOutput({tag, "Latency"}, edges, expEdges);
   endtask

   // One full session: queue the expected result, stream the bits (with an
   // optional valid gap and an optional stray start during RUN), then score.
   task automatic applyStimulus(input int n, input logic [3:0] gold,
                                input logic [15:0] bits, input int gapIdx,
                                input int gapLen, input bit pokeStart);
      logic [3:0] m;
      expect_t    e;
      m = 4'h0;
      for (int j = 0; j < n; j++) m = modelStep(m, bits[j]);
      e.sig  = m;
      e.pass = (m == gold);
      scoreQ.push_back(e);

      start  = 1'b1;
      len    = CNT_W'(n);
      golden = gold;
      step();
      start  = 1'b0;
      checkOutput("clearBusy", busy, 1);
      checkOutput("clearRdy", bit_rdy, 0);

      if (n > 0) begin
         step();
         checkOutput("clrSig", sig, 0);
         checkOutput("clrPass", pass, 0);
         m = 4'h0;
         for (int j = 0; j < n; j++) begin
            if (j == gapIdx) begin
               bit_vld = 1'b0;
               for (int g = 0; g < gapLen; g++) begin
                  step();
                  checkOutput("gapHold", sig, m);
               end
            end
            bit_vld = 1'b1;
            bit_i   = bits[j];
            if (pokeStart) begin
               start = 1'b1;
               len   = '0;
            end
            checkOutput("runRdy", bit_rdy, 1);
            step();
            m = modelStep(m, bits[j]);
            checkOutput("sigStep", sig, m);
         end
         bit_vld = 1'b0;
         start   = 1'b0;
         checkOutput("checkRdy", bit_rdy, 0);
         checkOutput("checkDone", done, 0);
         waitDone(1, "run");
      end else begin
         waitDone(2, "empty");
      end

      if (scoreQ.size() == 0) begin
         checkOutput("scoreUnderflow", 1, 0);
      end else begin
         e = scoreQ.pop_front();
         checkOutput("doneSig", sig, e.sig);
         checkOutput("donePass", pass, e.pass);
         checkOutput("doneBusy", busy, 0);
         step();
         checkOutput("donePulse", done, 0);
         checkOutput("passHold", pass, e.pass);
         checkOutput("sigHold", sig, e.sig);
      end
   endtask

   // Absolute guard so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Main sequence.
   initial begin
      logic [15:0] rndBits;
      int          rndLen;
      logic [3:0]  rndGold;
      int          doneSeen;

      rst_b   = 1'b0;
      start   = 1'b0;
      abort   = 1'b0;
      bit_i   = 1'b0;
      bit_vld = 1'b0;
      len     = '0;
      golden  = 4'h0;
      #12;
      checkOutput("rstSig", sig, 0);
      checkOutput("rstPass", pass, 0);
      checkOutput("rstDone", done, 0);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstRdy", bit_rdy, 0);
      @(negedge clk);
      rst_b = 1'b1;
      step();

      applyStimulus(4, 4'hB, 16'h000D, -1, 0, 1'b0);
      checkOutput("planSigB", sig, 4'hB);
      checkOutput("planPass", pass, 1);

      applyStimulus(4, 4'hA, 16'h000D, -1, 0, 1'b0);
      checkOutput("wrongGoldSig", sig, 4'hB);
      checkOutput("wrongGoldPass", pass, 0);

      applyStimulus(4, 4'hB, 16'h000D, 2, 3, 1'b0);
      checkOutput("gapFinalSig", sig, 4'hB);

      applyStimulus(0, 4'h0, 16'h0000, -1, 0, 1'b0);
      checkOutput("emptyPass", pass, 1);
      applyStimulus(0, 4'h3, 16'h0000, -1, 0, 1'b0);
      checkOutput("emptyFail", pass, 0);

      applyStimulus(4, 4'hB, 16'h000D, -1, 0, 1'b1);
      checkOutput("ignoreStartSig", sig, 4'hB);

      for (int r = 0; r < 3; r++) begin
         rndBits = 16'($urandom);
         rndLen  = $urandom_range(1, 16);
         rndGold = 4'($urandom);
         applyStimulus(rndLen, rndGold, rndBits, -1, 0, 1'b0);
      end

      start  = 1'b1;
      len    = 8'd4;
      golden = 4'hB;
      step();
      start = 1'b0;
      step();
      bit_vld = 1'b1;
      bit_i   = 1'b1;
      step();
      bit_i = 1'b0;
      step();
      checkOutput("abortPreSig", sig, 4'h2);
      abort = 1'b1;
      bit_i = 1'b1;
      step();
      abort   = 1'b0;
      bit_vld = 1'b0;
      checkOutput("abortBusy", busy, 0);
      checkOutput("abortSig", sig, 4'h2);
      checkOutput("abortRdy", bit_rdy, 0);
      doneSeen = 0;
      for (int k = 0; k < 4; k++) begin
         if (done !== 1'b0) doneSeen++;
         step();
      end
      checkOutput("abortNoDone", doneSeen, 0);
      checkOutput("abortSigFrozen", sig, 4'h2);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      checkOutput("restartClrSig", sig, 0);
      abort = 1'b1;
      step();
      abort = 1'b0;
      checkOutput("abortIdle", busy, 0);

      start  = 1'b1;
      len    = 8'd4;
      golden = 4'hB;
      step();
      start = 1'b0;
      step();
      bit_vld = 1'b1;
      bit_i   = 1'b1;
      step();
      bit_i = 1'b0;
      step();
      bit_vld = 1'b0;
      checkOutput("preRstBusy", busy, 1);
      checkOutput("preRstSig", sig, 4'h2);
      @(negedge clk);
      rst_b = 1'b0;
      #1;
      checkOutput("midRstSig", sig, 0);
      checkOutput("midRstPass", pass, 0);
      checkOutput("midRstDone", done, 0);
      checkOutput("midRstBusy", busy, 0);
      checkOutput("midRstRdy", bit_rdy, 0);
      @(negedge clk);
      rst_b = 1'b1;
      step();
      checkOutput("postRstBusy", busy, 0);
      checkOutput("postRstDone", done, 0);

      checkOutput("queueEmpty", scoreQ.size(), 0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
